// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM states,
// the latched request payload, lane-mask and alignment functions.
package lsu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Fields of an accepted request that are still needed after the accept cycle
  typedef struct packed {
    size_e             size;
    logic              sgn;
    logic [2:0]        off;
    logic [DATA_W-1:0] wdata;
  } req_lat_t;

  function automatic logic [DATA_W-1:0] size_mask(input size_e size);
    logic [DATA_W-1:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Only the low three address bits can make an access misaligned
  function automatic logic misaligned(input logic [2:0] addr, input size_e size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr[0];
      SZ_W:    mis = |addr[1:0];
      default: mis = |addr[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response bus and data-memory pin bundle for the load/store unit.
interface lsu_req_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: extracts/extends a load lane and merges a store lane
// into a doubleword. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]        off_i,
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] store_o
);

  logic [5:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;

  assign shamt     = {off_i, 3'b000};
  assign shifted   = rdata_i >> shamt;
  assign lane_mask = size_mask(size_i) << shamt;

  always_comb begin
    load_o = shifted;
    case (size_i)
      SZ_B:    load_o = signed_i ? {{56{shifted[7]}},  shifted[7:0]}  : {56'b0, shifted[7:0]};
      SZ_H:    load_o = signed_i ? {{48{shifted[15]}}, shifted[15:0]} : {48'b0, shifted[15:0]};
      SZ_W:    load_o = signed_i ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
      default: load_o = shifted;
    endcase
  end

  assign store_o = (rdata_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the 64-bit data-memory interface: one load/store at a time,
// lane extraction for loads, read-modify-write for sub-doubleword stores.
module load_store_unit
  import lsu_pkg::*;
(
  input logic       clock,
  input logic       reset_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  state_e            state_q;
  req_lat_t          lat_q;
  logic              resp_valid_q;
  logic              resp_error_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_write_data_q;

  size_e             req_size_c;
  logic [DATA_W-1:0] load_d;
  logic [DATA_W-1:0] merge_d;

  assign req_size_c = size_e'(req.req_size);

  lsu_lane_align u_align (
    .off_i    (lat_q.off),
    .size_i   (lat_q.size),
    .signed_i (lat_q.sgn),
    .rdata_i  (mem.mem_read_data),
    .wdata_i  (lat_q.wdata),
    .load_o   (load_d),
    .store_o  (merge_d)
  );

  // Control FSM with registered datapath outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      lat_q            <= '0;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req.req_valid) begin
            lat_q         <= '{size: req_size_c, sgn: req.req_signed,
                               off: req.req_addr[2:0], wdata: req.req_wdata};
            mem_address_q <= {3'b000, req.req_addr[ADDR_W-1:3]};
            resp_error_q  <= 1'b0;
            resp_rdata_q  <= '0;
            if (misaligned(req.req_addr[2:0], req_size_c)) begin
              resp_error_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else if (!req.req_write) begin
              state_q <= ST_LOAD;
            end else if (req_size_c == SZ_D) begin
              mem_write_data_q <= req.req_wdata;
              state_q          <= ST_WRITE;
            end else begin
              state_q <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata_q <= load_d;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RMW_RD: begin
          mem_write_data_q <= merge_d;
          state_q          <= ST_WRITE;
        end
        ST_WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is held low while reset is asserted even though the state reads IDLE
  assign req.req_ready  = reset_n && (state_q == ST_IDLE);
  assign req.resp_valid = resp_valid_q;
  assign req.resp_error = resp_error_q;
  assign req.resp_rdata = resp_rdata_q;

  assign mem.mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign mem.mem_write      = (state_q == ST_WRITE);
  assign mem.mem_address    = mem_address_q;
  assign mem.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small doubleword memory model.
module tb_load_store_unit;

  logic clk;
  logic rst_n;

  lsu_req_if rq ();
  lsu_mem_if mb ();

  load_store_unit dut (
    .clock   (clk),
    .reset_n (rst_n),
    .req     (rq),
    .mem     (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge, bench preload port
  logic [63:0] mem_arr [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [63:0] pl_data;

  assign mb.mem_read_data = mem_arr[mb.mem_address[3:0]];

  always @(posedge clk) begin
    if (mb.mem_write)  mem_arr[mb.mem_address[3:0]] <= mb.mem_write_data;
    else if (pl_en)    mem_arr[pl_idx] <= pl_data;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [63:0] data);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Presents one request for the accept edge; returns 1 time unit into cycle 1
  task automatic start(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd);
    @(negedge clk);
    rq.req_valid  = 1'b1;
    rq.req_write  = wr;
    rq.req_size   = sz;
    rq.req_signed = sg;
    rq.req_addr   = addr;
    rq.req_wdata  = wd;
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_arr[i] = 64'h0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_size = 2'b00;
    rq.req_signed = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
    rst_n = 1'b0;

    // Reset state
    #2;
    check("rst_ready",   64'(rq.req_ready),  64'd0);
    check("rst_rvalid",  64'(rq.resp_valid), 64'd0);
    check("rst_rdata",   rq.resp_rdata,      64'd0);
    check("rst_mread",   64'(mb.mem_read),   64'd0);
    check("rst_mwrite",  64'(mb.mem_write),  64'd0);
    check("rst_maddr",   mb.mem_address,     64'd0);
    check("rst_mwdata",  mb.mem_write_data,  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready",   64'(rq.req_ready),  64'd1);

    preload(4'd5, 64'h5);
    preload(4'd1, 64'h80FF_0000_0000_0000);
    preload(4'd2, 64'h1111_2222_3333_4444);
    preload(4'd3, 64'hAAAA_BBBB_CCCC_DDDD);

    // Doubleword load
    start(1'b0, 2'b11, 1'b0, 64'h28, 64'h0);
    check("dl_c1_mread", 64'(mb.mem_read),   64'd1);
    check("dl_c1_maddr", mb.mem_address,     64'd5);
    check("dl_c1_ready", 64'(rq.req_ready),  64'd0);
    check("dl_c1_rv",    64'(rq.resp_valid), 64'd0);
    step();
    check("dl_c2_rv",    64'(rq.resp_valid), 64'd1);
    check("dl_c2_rdata", rq.resp_rdata,      64'h5);
    check("dl_c2_err",   64'(rq.resp_error), 64'd0);
    step();
    check("dl_c3_rv",    64'(rq.resp_valid), 64'd0);
    check("dl_c3_ready", 64'(rq.req_ready),  64'd1);

    // Byte load, signed then unsigned, top byte of word 1
    start(1'b0, 2'b00, 1'b1, 64'h0F, 64'h0);
    step();
    check("lb_s_rv",     64'(rq.resp_valid), 64'd1);
    check("lb_s_rdata",  rq.resp_rdata,      64'hFFFF_FFFF_FFFF_FF80);
    step();
    start(1'b0, 2'b00, 1'b0, 64'h0F, 64'h0);
    step();
    check("lb_u_rdata",  rq.resp_rdata,      64'h80);
    step();

    // Halfword store via read-modify-write
    start(1'b1, 2'b01, 1'b0, 64'h12, 64'hBEEF);
    check("sh_c1_mread",  64'(mb.mem_read),  64'd1);
    check("sh_c1_mwrite", 64'(mb.mem_write), 64'd0);
    step();
    check("sh_c2_mwrite", 64'(mb.mem_write), 64'd1);
    check("sh_c2_mread",  64'(mb.mem_read),  64'd0);
    check("sh_c2_maddr",  mb.mem_address,    64'd2);
    check("sh_c2_wdata",  mb.mem_write_data, 64'h1111_2222_BEEF_4444);
    check("sh_c2_rv",     64'(rq.resp_valid), 64'd0);
    step();
    check("sh_c3_rv",     64'(rq.resp_valid), 64'd1);
    check("sh_c3_rdata",  rq.resp_rdata,      64'd0);
    check("sh_mem2",      mem_arr[2],         64'h1111_2222_BEEF_4444);
    step();

    // Signed word load of the freshly merged low word
    start(1'b0, 2'b10, 1'b1, 64'h10, 64'h0);
    step();
    check("lw_s_rdata",  rq.resp_rdata,      64'hFFFF_FFFF_BEEF_4444);
    step();
    // Unsigned halfword load at offset 6
    start(1'b0, 2'b01, 1'b0, 64'h16, 64'h0);
    step();
    check("lh_u_rdata",  rq.resp_rdata,      64'h1111);
    step();

    // Doubleword store goes straight to WRITE
    start(1'b1, 2'b11, 1'b0, 64'h30, 64'hDEAD_BEEF_0123_4567);
    check("sd_c1_mwrite", 64'(mb.mem_write), 64'd1);
    check("sd_c1_mread",  64'(mb.mem_read),  64'd0);
    check("sd_c1_wdata",  mb.mem_write_data, 64'hDEAD_BEEF_0123_4567);
    step();
    check("sd_c2_rv",     64'(rq.resp_valid), 64'd1);
    check("sd_mem6",      mem_arr[6],         64'hDEAD_BEEF_0123_4567);
    step();

    // Misaligned word load
    start(1'b0, 2'b10, 1'b0, 64'h06, 64'h0);
    check("mis_c1_rv",     64'(rq.resp_valid), 64'd1);
    check("mis_c1_err",    64'(rq.resp_error), 64'd1);
    check("mis_c1_rdata",  rq.resp_rdata,      64'd0);
    check("mis_c1_mread",  64'(mb.mem_read),   64'd0);
    check("mis_c1_mwrite", 64'(mb.mem_write),  64'd0);
    step();
    check("mis_c2_rv",     64'(rq.resp_valid), 64'd0);
    check("mis_c2_mrw",    64'({mb.mem_read, mb.mem_write}), 64'd0);

    // Misaligned halfword store leaves memory alone
    start(1'b1, 2'b01, 1'b0, 64'h13, 64'hFFFF);
    check("miss_c1_err",   64'(rq.resp_error), 64'd1);
    check("miss_c1_mwrite", 64'(mb.mem_write), 64'd0);
    step();
    check("miss_mem2",     mem_arr[2],         64'h1111_2222_BEEF_4444);

    // Back-to-back with req_valid held; busy-time input changes must be ignored
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_size = 2'b11;
    rq.req_signed = 1'b0; rq.req_addr = 64'h28; rq.req_wdata = '0;
    step();
    rq.req_addr = 64'h08;
    check("b2b_c1_ready", 64'(rq.req_ready),  64'd0);
    step();
    check("b2b_c2_ready", 64'(rq.req_ready),  64'd0);
    check("b2b_c2_rv",    64'(rq.resp_valid), 64'd1);
    check("b2b_c2_rdata", rq.resp_rdata,      64'h5);
    step();
    check("b2b_c3_ready", 64'(rq.req_ready),  64'd1);
    check("b2b_c3_rv",    64'(rq.resp_valid), 64'd0);
    step();
    rq.req_valid = 1'b0;
    check("b2b_c4_mread", 64'(mb.mem_read),   64'd1);
    check("b2b_c4_maddr", mb.mem_address,     64'd1);
    check("b2b_c4_rv",    64'(rq.resp_valid), 64'd0);
    step();
    check("b2b_c5_rv",    64'(rq.resp_valid), 64'd1);
    check("b2b_c5_rdata", rq.resp_rdata,      64'h80FF_0000_0000_0000);
    step();

    // Reset asserted inside the WRITE cycle of a halfword store
    start(1'b1, 2'b01, 1'b0, 64'h18, 64'h1234);
    step();
    check("rw_c2_mwrite", 64'(mb.mem_write), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_mwrite_drop", 64'(mb.mem_write), 64'd0);
    check("rw_ready_rst",   64'(rq.req_ready), 64'd0);
    step();
    check("rw_mem3",        mem_arr[3],         64'hAAAA_BBBB_CCCC_DDDD);
    check("rw_rv_rst",      64'(rq.resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rw_ready_rel",   64'(rq.req_ready), 64'd1);
    check("rw_mrw_rel",     64'({mb.mem_read, mb.mem_write}), 64'd0);
    step();
    check("rw_rv_after",    64'(rq.resp_valid), 64'd0);
    // A fresh load behaves with normal latency, showing the FSM is back in IDLE
    start(1'b0, 2'b11, 1'b0, 64'h18, 64'h0);
    check("rw_ld_c1_mread", 64'(mb.mem_read),   64'd1);
    step();
    check("rw_ld_c2_rv",    64'(rq.resp_valid), 64'd1);
    check("rw_ld_c2_rdata", rq.resp_rdata,      64'hAAAA_BBBB_CCCC_DDDD);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
